// File: rtl/lmsm_sequencer_pkg.sv
// Shared constants, field positions and types for the LM/SM decode-front sequencer.
package lmsm_sequencer_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned MASK_W  = 8;
    localparam int unsigned REG_AW  = 3;

    localparam logic [3:0]         OP_LM     = 4'b1100;
    localparam logic [3:0]         OP_SM     = 4'b1101;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h7000;

    localparam int unsigned OPC_HI  = 15;
    localparam int unsigned OPC_LO  = 12;
    localparam int unsigned RA_HI   = 11;
    localparam int unsigned RA_LO   = 9;
    localparam int unsigned MASK_HI = 7;
    localparam int unsigned MASK_LO = 0;

    typedef enum logic {IDLE, EXPAND} state_t;

    function automatic logic is_lmsm(input logic [INSTR_W-1:0] instr);
        return (instr[OPC_HI:OPC_LO] == OP_LM) || (instr[OPC_HI:OPC_LO] == OP_SM);
    endfunction

    // True when a non-zero mask holds exactly one set bit.
    function automatic logic single_bit(input logic [MASK_W-1:0] mask);
        return (mask & (mask - MASK_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// IF/ID-side and decode-side handshake bundle of the sequencer.
interface lmsm_sequencer_if;
    import lmsm_sequencer_pkg::*;

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [REG_AW-1:0]  out_rd;
    logic [REG_AW-1:0]  out_offset;
    logic               out_last;
    logic               out_ready;

    modport master (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_rd, out_offset, out_last
    );

    modport slave (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_rd, out_offset, out_last
    );
endinterface

// File: rtl/lmsm_sequencer_lsb_find.sv
// Lowest-set-bit finder for the register mask; purely combinational.
module lsb_find
    import lmsm_sequencer_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    output logic [REG_AW-1:0] idx,
    output logic              found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = REG_AW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into per-register micro-ops, passes other instructions through a one-entry slot.
// Optional micro-op performance counter enabled by defining LMSM_PERF_EN.
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
`ifdef LMSM_PERF_EN
    output logic [15:0]          perf_uops,
`endif
    lmsm_sequencer_if.master     bus
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [MASK_W-1:0]  remaining_q, remaining_d;
    logic [REG_AW-1:0]  count_q, count_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [REG_AW-1:0]  offset_q, offset_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;

    logic [MASK_W-1:0]  find_mask;
    logic [MASK_W-1:0]  mask_clr;
    logic [REG_AW-1:0]  lsb_idx;
    logic               lsb_found;
    logic               accept;

    assign find_mask = (state_q == EXPAND) ? remaining_q : bus.in_instr[MASK_HI:MASK_LO];
    assign mask_clr  = find_mask & ~(MASK_W'(1) << lsb_idx);

    lsb_find u_lsb_find (
        .mask  (find_mask),
        .idx   (lsb_idx),
        .found (lsb_found)
    );

    assign bus.in_ready   = (state_q == IDLE) && (!valid_q || bus.out_ready) && !flush;
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_instr  = instr_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_offset = offset_q;
    assign bus.out_last   = last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            rd_q        <= '0;
            offset_q    <= '0;
            last_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            offset_q    <= offset_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
        end
    end

    // EXPAND is left only once the final micro-op is consumed, giving one accept bubble.
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        rd_d        = rd_q;
        offset_d    = offset_q;
        last_d      = last_q;
        valid_d     = valid_q;

        if (flush) begin
            valid_d     = 1'b0;
            state_d     = IDLE;
            remaining_d = '0;
            count_d     = '0;
        end else if (state_q == EXPAND) begin
            if (bus.out_ready) begin
                if (!lsb_found) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    valid_d     = 1'b1;
                    rd_d        = lsb_idx;
                    offset_d    = count_q;
                    last_d      = single_bit(remaining_q);
                    remaining_d = mask_clr;
                    count_d     = count_q + REG_AW'(1);
                end
            end
        end else if (accept) begin
            valid_d  = 1'b1;
            offset_d = '0;
            last_d   = 1'b1;
            if (!is_lmsm(bus.in_instr)) begin
                instr_d = bus.in_instr;
                rd_d    = bus.in_instr[RA_HI:RA_LO];
            end else if (!lsb_found) begin
                instr_d = NOP_INSTR;
                rd_d    = '0;
            end else begin
                instr_d     = bus.in_instr;
                rd_d        = lsb_idx;
                last_d      = single_bit(find_mask);
                remaining_d = mask_clr;
                count_d     = REG_AW'(1);
                if (mask_clr != '0) begin
                    state_d = EXPAND;
                end
            end
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

`ifdef LMSM_PERF_EN
    // Saturating count of consumed micro-ops; cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_uops <= '0;
        end else if (valid_q && bus.out_ready && (perf_uops != 16'hFFFF)) begin
            perf_uops <= perf_uops + 16'd1;
        end
    end
`endif

endmodule

// File: doc/lmsm_sequencer.md
# lmsm_sequencer

Decode-front micro-sequencer between the IF/ID pipeline register and the decode-stage controller. Ordinary instructions pass through a one-entry registered slot. LM (opcode 1100) and SM (opcode 1101) are expanded into one micro-op per set bit of their 8-bit register mask, and fetch is stalled until expansion completes. Each micro-op carries the original instruction, so the controller still sees the LM/SM opcode, plus the target register and the word offset from base RA for the EX/MEM address adder.

## Interface
- INSTR_W, 16, instruction width
- MASK_W, 8, LM/SM register-mask width, taken from instr[7:0]
- REG_AW, 3, register index and offset width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  branch/jump flush from EX; synchronous
- in_valid  in  1  IF/ID holds an instruction
- in_instr  in  INSTR_W  instruction from IF/ID
- in_ready  out  1  sequencer accepts this cycle; low stalls PC and IF/ID
- out_valid  out  1  micro-op valid to decode
- out_instr  out  INSTR_W  micro-op instruction; [15:12] drives the controller opcode input
- out_rd  out  REG_AW  target register: mask bit index for LM/SM, otherwise instr[11:9]
- out_offset  out  REG_AW  word offset from RA, 0-based count of micro-ops already emitted
- out_last  out  1  final micro-op of this instruction
- out_ready  in  1  decode/ID-EX can take the micro-op

## Operation
- States are IDLE and EXPAND. Registers are the held instruction, the remaining mask (8 bits) and the count (3 bits).
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. accept = in_valid && in_ready.
- **Accept, non-LM/SM:** load the output slot with {in_instr, instr[11:9], 0, last=1}. State stays IDLE.
- **Accept, LM/SM, mask==0:** load the output slot with NOP 16'h7000 (opcode 0111, decodes to NOP), rd=0, offset=0, last=1. State stays IDLE.
- **Accept, LM/SM, mask!=0:**
  - Emit the lowest set bit i: out_rd=i, offset=0, last=(popcount==1).
  - remaining = mask with bit i cleared; count = 1.
  - If remaining != 0, go to EXPAND.
- **EXPAND, out_ready=1:**
  - Emit the lowest set bit j of remaining: out_rd=j, out_offset=count, out_last=(remaining has exactly one bit).
  - Clear bit j; count++.
  - When remaining becomes 0, go to IDLE.
- **EXPAND, out_ready=0:** all outputs and state hold.
- **IDLE, out_ready=1, no accept:** out_valid <= 0.
- Register order is ascending: mask bit k maps to Rk. The offset never exceeds 7, so it cannot wrap.
- **flush:** out_valid <= 0, state <= IDLE, remaining <= 0, count <= 0. An input presented in the same cycle is dropped.
- **rst:** same as flush, plus out_instr, out_rd, out_offset and out_last are cleared to 0. in_ready reads 1 after reset.
- **Priority:** rst > flush > out_ready/accept.

## Timing
- Pass-through latency is 1 cycle, accept to out_valid.
- A mask with N set bits produces N consecutive out_valid cycles when out_ready is held high.
- in_ready is low from the cycle after an LM/SM accept until the cycle after out_last is consumed. This gives one bubble cycle of accept after each expansion.
- The output slot is stable while out_valid && !out_ready.
- Back-to-back non-LM/SM instructions sustain 1 per cycle.

## Configuration
- **LMSM_PERF_EN defined:** adds output perf_uops (16 bits). It increments on every out_valid && out_ready, saturates at 16'hFFFF, and clears on rst only.
- **LMSM_PERF_EN undefined:** no port, no counter logic.

## Structure
- Shared package holds:
  - OP_LM = 4'b1100, OP_SM = 4'b1101
  - NOP_INSTR = 16'h7000
  - field positions: opcode [15:12], RA [11:9], mask [7:0]
  - state enum {IDLE, EXPAND}
- Sub-module lsb_find: 8-bit mask in, 3-bit index of the lowest set bit plus a found flag, combinational. One instance is used for both the accept and EXPAND paths, through a mux on its input.

## Test plan
- ADD 16'h1234, out_ready=1: next cycle out_valid=1, out_instr=16'h1234, out_rd=1, out_offset=0, out_last=1.
- LM 16'hC2A5 (mask A5): four micro-ops with out_rd 0,2,5,7 and offsets 0,1,2,3. out_last is high only on the 4th. in_ready is 0 for 4 cycles after accept.
- SM 16'hD400 (mask 0): a single micro-op out_instr=16'h7000, out_last=1. in_ready stays 1.
- LM mask 8'hFF with out_ready low for 3 cycles after the 2nd micro-op: outputs hold at rd=1/offset=1. Then rd 2..7 follow with no skip; offset 7 is last.
- flush after the 2nd micro-op of LM mask 8'h0F: out_valid=0 next cycle, in_ready=1. A following ADD passes with 1-cycle latency.
- rst mid-expansion: next cycle all outputs are 0 and in_ready=1. With LMSM_PERF_EN, perf_uops reads 0.
